// File: rtl/line_refill_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_refill_unit_pkg
// Description : Shared widths, derived line geometry and types for the refill
//               engine and the cache that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package line_refill_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LINE_WIDTH = 256;
  localparam int ADDR_WIDTH = 32;

  localparam int DATA_PER_LINE    = LINE_WIDTH / DATA_WIDTH;
  localparam int LINE_INDEX_WIDTH = (DATA_PER_LINE > 1) ? $clog2(DATA_PER_LINE) : 1;
  localparam int DATA_BYTE_OFFSET = $clog2(DATA_WIDTH / 8);
  localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  typedef logic [LINE_WIDTH-1:0] line_t;

endpackage : line_refill_unit_pkg
`default_nettype wire

// File: rtl/line_refill_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : line_refill_unit_if
// Description : Cache-side line port plus single-word memory bus of the
//               refill engine; slave = engine view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_refill_unit_if;
  import line_refill_unit_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  line_t                 req_wline;
  logic                  resp_valid;
  line_t                 resp_rline;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wline,
    output req_ready, resp_valid, resp_rline,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wline,
    input  req_ready, resp_valid, resp_rline,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface : line_refill_unit_if
`default_nettype wire

// File: rtl/line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : line_refill_unit
// Description : Splits one cache line read/write into sequential word
//               transactions and returns the assembled read line in one beat.
// Revision    : 1.0 - initial release
// ============================================================================
module line_refill_unit
  import line_refill_unit_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  line_refill_unit_if.slave  bus
);

  localparam logic [LINE_INDEX_WIDTH-1:0] c_last_beat = LINE_INDEX_WIDTH'(DATA_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0]       c_line_mask = {ADDR_WIDTH{1'b1}} << LINE_BYTE_OFFSET;

  refill_state_t               r_state;
  refill_state_t               w_state_nxt;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic                        r_write;
  line_t                       r_wline;
  line_t                       r_line;
  logic [LINE_INDEX_WIDTH-1:0] r_beat;

  wire logic w_accept   = (r_state == IDLE) && bus.req_valid;
  wire logic w_mem_resp = (r_state == WAIT) && bus.mem_resp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid)     w_state_nxt = REQ;
      REQ:     if (bus.mem_req_ready) w_state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid) begin
                 w_state_nxt = (r_beat == c_last_beat) ? DONE : REQ;
               end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat counter saturates on the last word so the address offset never
  // carries into the line index/tag bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_write <= 1'b0;
      r_wline <= '0;
      r_line  <= '0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_base  <= bus.req_addr & c_line_mask;
      r_write <= bus.req_write;
      r_wline <= bus.req_wline;
      r_beat  <= '0;
    end else if (w_mem_resp) begin
      if (!r_write) begin
        r_line[r_beat*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
      end
      if (r_beat != c_last_beat) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Word address/data come straight from latched state, so they cannot move
  // while a request waits for mem_req_ready.
  always_comb begin
    bus.req_ready     = (r_state == IDLE);
    bus.resp_valid    = (r_state == DONE);
    bus.resp_rline    = r_line;
    bus.mem_req_valid = (r_state == REQ);
    bus.mem_we        = r_write;
    bus.mem_addr      = r_base | (ADDR_WIDTH'(r_beat) << DATA_BYTE_OFFSET);
    bus.mem_wdata     = r_wline[r_beat*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule : line_refill_unit
`default_nettype wire

// File: tb/tb_line_refill_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_refill_unit
// Description : Directed self-checking bench with memory responder and
//               scoreboard queues for word transactions and line responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_refill_unit;
  import line_refill_unit_pkg::*;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic  is_write;
    line_t line;
    int    cyc;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_refill_unit_if bus ();

  line_refill_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int acc_cnt     = 0;
  int stall_beat  = -1;
  int stall_left  = 0;
  int dly_beat    = -1;
  int dly_cycles  = 0;
  bit stale_pulse = 1'b0;
  bit pend        = 1'b0;

  task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: decides ready for the coming edge, checks accepted
  // words against the scoreboard, answers after a configurable delay.
  initial begin
    int                    pend_cnt;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  prev_valid, prev_ready, prev_we;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [DATA_WIDTH-1:0] prev_wdata;
    mem_exp_t              e;
    pend_cnt   = 0;
    pend_addr  = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_we    = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (stale_pulse) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        stale_pulse        = 1'b0;
      end else if (pend) begin
        if (pend_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = pend_addr + 32'd1;
          pend               = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (rst && prev_valid && !prev_ready) begin
        check("mem_req_valid_held", bus.mem_req_valid, 1'b1);
        check("mem_addr_stable", bus.mem_addr, prev_addr);
        check("mem_we_stable", bus.mem_we, prev_we);
        check("mem_wdata_stable", bus.mem_wdata, prev_wdata);
      end
      bus.mem_req_ready = 1'b1;
      if (bus.mem_req_valid && acc_cnt == stall_beat && stall_left > 0) begin
        bus.mem_req_ready = 1'b0;
        stall_left--;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        check("mem_req_expected", mem_q.size() != 0, 1'b1);
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_we", bus.mem_we, e.we);
          if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
        end
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
        pend_cnt  = (acc_cnt == dly_beat) ? dly_cycles : 0;
        acc_cnt++;
      end
      prev_valid = bus.mem_req_valid;
      prev_ready = bus.mem_req_ready;
      prev_addr  = bus.mem_addr;
      prev_we    = bus.mem_we;
      prev_wdata = bus.mem_wdata;
    end
  end

  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        check("resp_expected", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          check("resp_cycle", cyc, r.cyc);
          if (!r.is_write) check("resp_rline", bus.resp_rline, r.line);
        end
      end
    end
  end

  // Called at a negedge; pushes word and line expectations, raises req_valid.
  // The response is expected 17+extra negedges later (t+17 with zero wait).
  task automatic start_op(input bit wr, input logic [ADDR_WIDTH-1:0] addr,
                          input line_t wline, input int extra, input bit hold);
    line_t                 exp_line;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] waddr;
    exp_line = '0;
    base     = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < DATA_PER_LINE; i++) begin
      waddr = base + 32'(i * 4);
      mem_q.push_back('{addr: waddr, we: wr, wdata: wline[i*DATA_WIDTH +: DATA_WIDTH]});
      exp_line[i*DATA_WIDTH +: DATA_WIDTH] = waddr + 32'd1;
    end
    resp_q.push_back('{is_write: wr, line: exp_line, cyc: cyc + 17 + extra});
    acc_cnt       = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wline = wline;
    if (!hold) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("resp_timeout", bus.resp_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_resp_rline"}, bus.resp_rline, '0);
    check({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
    check({tag, "_mem_we"}, bus.mem_we, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
  endtask

  initial begin
    line_t wl;
    int    n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wline = '0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // zero-wait read
    check("req_ready_idle", bus.req_ready, 1'b1);
    start_op(1'b0, 32'h8000_0014, '0, 0, 1'b0);
    wait_resp();
    @(negedge clk);

    // write line
    for (int i = 0; i < DATA_PER_LINE; i++) wl[i*DATA_WIDTH +: DATA_WIDTH] = 32'hA0 + 32'(i);
    start_op(1'b1, 32'h1000_0000, wl, 0, 1'b0);
    wait_resp();
    @(negedge clk);

    // ready stall on beat 2, response delay on beat 5
    stall_beat = 2; stall_left = 3;
    dly_beat   = 5; dly_cycles = 2;
    start_op(1'b0, 32'h2000_0040, '0, 5, 1'b0);
    wait_resp();
    @(negedge clk);
    stall_beat = -1; dly_beat = -1;

    // reset in WAIT of beat 4
    start_op(1'b0, 32'h3000_0000, '0, 0, 1'b0);
    n = 0;
    while (acc_cnt < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("beat4_timeout", acc_cnt, 5);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("abort");
    mem_q.delete();
    resp_q.delete();
    pend = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    stale_pulse = 1'b1;
    repeat (3) @(negedge clk);
    check("stale_resp_valid", bus.resp_valid, 1'b0);
    check("stale_req_ready", bus.req_ready, 1'b1);
    check("stale_mem_req_valid", bus.mem_req_valid, 1'b0);
    start_op(1'b0, 32'h3000_0000, '0, 0, 1'b0);
    wait_resp();
    @(negedge clk);

    // req_valid held through an operation, next request right after
    start_op(1'b0, 32'h4000_0000, '0, 0, 1'b1);
    wait_resp();
    check("held_req_ready_done", bus.req_ready, 1'b0);
    for (int i = 0; i < DATA_PER_LINE; i++) wl[i*DATA_WIDTH +: DATA_WIDTH] = 32'h5500 + 32'(i);
    start_op(1'b1, 32'h5000_0020, wl, 1, 1'b1);
    @(negedge clk);
    check("held_req_ready_idle", bus.req_ready, 1'b1);
    @(negedge clk);
    check("held_mem_req_valid", bus.mem_req_valid, 1'b1);
    bus.req_valid = 1'b0;
    wait_resp();
    @(negedge clk);

    // top-of-address-space line
    start_op(1'b0, 32'hFFFF_FFE0, '0, 0, 1'b0);
    wait_resp();
    repeat (3) @(negedge clk);

    check("mem_q_drained", mem_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_line_refill_unit
`default_nettype wire
